// File: rtl/riscv_bus_pkg.sv
//------------------------------------------------------------------------------
// riscv_bus_pkg: address map, STATUS bit positions and address decoder shared by
// the data-memory bus responder and its console FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_bus_pkg;

    localparam logic [31:0] RAM_BASE        = 32'h0000_0000;
    localparam logic [31:0] TIME_LO_ADDR    = 32'h0001_0000;
    localparam logic [31:0] TIME_HI_ADDR    = 32'h0001_0004;
    localparam logic [31:0] TIMECMP_ADDR    = 32'h0001_0008;
    localparam logic [31:0] STATUS_ADDR     = 32'h0001_000C;
    localparam logic [31:0] CONSOLE_TX_ADDR = 32'h0001_0010;

    localparam int STAT_IRQ_PEND   = 0;
    localparam int STAT_FIFO_FULL  = 1;
    localparam int STAT_FIFO_EMPTY = 2;
    localparam int STAT_TX_OVF     = 3;
    localparam int STAT_CNT_LSB    = 8;
    localparam int STAT_CNT_MSB    = 15;

    typedef enum logic [2:0] {
        SEL_RAM     = 3'd0,
        SEL_TIME_LO = 3'd1,
        SEL_TIME_HI = 3'd2,
        SEL_TIMECMP = 3'd3,
        SEL_STATUS  = 3'd4,
        SEL_CONSOLE = 3'd5,
        SEL_NONE    = 3'd6
    } bus_sel_e;

    // Byte-lane bits are dropped before matching, so any byte address inside a
    // word selects that word.
    function automatic bus_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] ram_bytes);
        logic [31:0] w_word;
        w_word = {addr[31:2], 2'b00};
        if ((w_word - RAM_BASE) < ram_bytes) begin
            return SEL_RAM;
        end
        case (w_word)
            TIME_LO_ADDR:    return SEL_TIME_LO;
            TIME_HI_ADDR:    return SEL_TIME_HI;
            TIMECMP_ADDR:    return SEL_TIMECMP;
            STATUS_ADDR:     return SEL_STATUS;
            CONSOLE_TX_ADDR: return SEL_CONSOLE;
            default:         return SEL_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/console_txfifo.sv
//------------------------------------------------------------------------------
// console_txfifo: synchronous FIFO for console bytes; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module console_txfifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    // Storage is not reset, so the head is forced to zero whenever nothing is queued.
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_drop  = i_push && w_full && !w_pop_ok;

endmodule

`default_nettype wire

// File: rtl/riscv_dmem_bus.sv
//------------------------------------------------------------------------------
// riscv_dmem_bus: data-side responder for the single-cycle RISC-V core: word RAM,
// 64-bit timer with compare interrupt, status register and console TX FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module riscv_dmem_bus
    import riscv_bus_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_timer_irq,
    output logic        o_bus_err
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [31:0] r_ram [RAM_WORDS];
    logic [63:0] r_time;
    logic [15:0] r_presc;
    logic [31:0] r_timecmp;
    logic        r_irq_pend;
    logic        r_tx_ovf;
    logic        r_bus_err;

    bus_sel_e           w_sel;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_wr_ram;
    logic               w_wr_lo;
    logic               w_wr_hi;
    logic               w_wr_cmp;
    logic               w_wr_status;
    logic               w_wr_console;
    logic               w_tick;
    logic [63:0]        w_time_inc;
    logic [63:0]        w_time_nxt;
    logic               w_irq_set;
    logic               w_irq_clr;
    logic               w_ovf_clr;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FIFO_CW-1:0] w_fifo_count;
    logic               w_fifo_drop;
    logic               w_tx_valid;
    logic [31:0]        w_status;

    assign w_sel        = decode_addr(i_addr, RAM_BYTES);
    assign w_ram_idx    = i_addr[RAM_AW+1:2];
    assign w_wr_ram     = i_mem_write && (w_sel == SEL_RAM);
    assign w_wr_lo      = i_mem_write && (w_sel == SEL_TIME_LO);
    assign w_wr_hi      = i_mem_write && (w_sel == SEL_TIME_HI);
    assign w_wr_cmp     = i_mem_write && (w_sel == SEL_TIMECMP);
    assign w_wr_status  = i_mem_write && (w_sel == SEL_STATUS);
    assign w_wr_console = i_mem_write && (w_sel == SEL_CONSOLE);

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= i_wdata;
        end
    end

    // A CPU write to either half replaces that half of the incremented value.
    assign w_tick     = (r_presc == TICK_LAST);
    assign w_time_inc = r_time + {63'd0, w_tick};
    assign w_time_nxt = {w_wr_hi ? i_wdata : w_time_inc[63:32],
                         w_wr_lo ? i_wdata : w_time_inc[31:0]};
    assign w_irq_set  = w_tick && (w_time_nxt[31:0] == r_timecmp);
    assign w_irq_clr  = w_wr_status && i_wdata[STAT_IRQ_PEND];
    assign w_ovf_clr  = w_wr_status && i_wdata[STAT_TX_OVF];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time     <= '0;
            r_presc    <= '0;
            r_timecmp  <= 32'hFFFF_FFFF;
            r_irq_pend <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_time  <= w_time_nxt;
            r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            if (w_wr_cmp) begin
                r_timecmp <= i_wdata;
            end
            if (w_irq_set) begin
                r_irq_pend <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_pend <= 1'b0;
            end
            if (w_fifo_drop) begin
                r_tx_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_sel == SEL_NONE) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    console_txfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_txfifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_console),
        .i_data  (i_wdata[7:0]),
        .i_pop   (w_tx_valid && i_tx_ready),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_head  (o_tx_data),
        .o_drop  (w_fifo_drop)
    );

    assign w_tx_valid = !w_fifo_empty;

    always_comb begin
        w_status                              = '0;
        w_status[STAT_IRQ_PEND]               = r_irq_pend;
        w_status[STAT_FIFO_FULL]              = w_fifo_full;
        w_status[STAT_FIFO_EMPTY]             = w_fifo_empty;
        w_status[STAT_TX_OVF]                 = r_tx_ovf;
        w_status[STAT_CNT_MSB:STAT_CNT_LSB]   = 8'(w_fifo_count);
    end

    always_comb begin
        o_rdata = '0;
        case (w_sel)
            SEL_RAM:     o_rdata = r_ram[w_ram_idx];
            SEL_TIME_LO: o_rdata = r_time[31:0];
            SEL_TIME_HI: o_rdata = r_time[63:32];
            SEL_TIMECMP: o_rdata = r_timecmp;
            SEL_STATUS:  o_rdata = w_status;
            default:     o_rdata = '0;
        endcase
    end

    assign o_tx_valid  = w_tx_valid;
    assign o_timer_irq = r_irq_pend;
    assign o_bus_err   = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_bus.sv
//------------------------------------------------------------------------------
// tb_riscv_dmem_bus: directed, self-checking bench for riscv_dmem_bus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_riscv_dmem_bus;
    import riscv_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = TIME_LO_ADDR;
    logic [31:0] wdata = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        timer_irq;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    riscv_dmem_bus #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (8),
        .TICK_DIV   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_mem_write (mem_write),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_timer_irq (timer_irq),
        .o_bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_write = we;
        addr      = a;
        wdata     = d;
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
        put(1'b0, a, 32'd0);
        check(name, rdata, exp);
    endtask

    vec_t        vt [17];
    logic [7:0]  drain_exp [8];

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         "st0"};
        vt[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         "st10"};
        vt[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram10"};
        vt[3]  = '{1'b1, 32'h0000_0014, 32'h0000_0001, 1'b0, 32'h0,         "st14"};
        vt[4]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h0000_0001, "ram14"};
        vt[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram10b"};
        vt[6]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0,         "st20"};
        vt[7]  = '{1'b1, 32'h0000_0020, 32'hAAAA_5555, 1'b1, 32'h1234_5678, "rdw_old"};
        vt[8]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hAAAA_5555, "rdw_new"};
        vt[9]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0,         "st_top"};
        vt[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'hCAFE_F00D, "ram_top"};
        vt[11] = '{1'b1, TIMECMP_ADDR,  32'h8000_0000, 1'b0, 32'h0,         "st_cmp"};
        vt[12] = '{1'b0, TIMECMP_ADDR,  32'h0,         1'b1, 32'h8000_0000, "tcmp"};
        vt[13] = '{1'b0, CONSOLE_TX_ADDR, 32'h0,       1'b1, 32'h0,         "con_rd"};
        vt[14] = '{1'b0, STATUS_ADDR,   32'h0,         1'b1, 32'h0000_0004, "stat_idle"};
        vt[15] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, "ram0"};
        vt[16] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_unal"};
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};

        // Reset state
        step();
        step();
        put(1'b0, TIMECMP_ADDR, 32'd0);
        check("rst_tcmp", rdata, 32'hFFFF_FFFF);
        check("rst_txv", {31'd0, tx_valid}, 32'd0);
        check("rst_txd", {24'd0, tx_data}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        check("rst_berr", {31'd0, bus_err}, 32'd0);
        rd(TIME_LO_ADDR, "rst_tlo", 32'd0);
        reset = 1'b1;
        rd(TIME_LO_ADDR, "tlo_0", 32'd0);
        step();
        rd(TIME_LO_ADDR, "tlo_1", 32'd1);

        // RAM and register vectors
        for (int i = 0; i < 17; i++) begin
            put(vt[i].we, vt[i].a, vt[i].d);
            if (vt[i].chk) begin
                check(vt[i].nm, rdata, vt[i].exp);
            end
            step();
        end

        // Timer compare
        put(1'b1, TIMECMP_ADDR, 32'd20);
        step();
        put(1'b1, TIME_LO_ADDR, 32'd0);
        step();
        for (int k = 0; k < 22; k++) begin
            rd(TIME_LO_ADDR, "tmr_lo", 32'(k));
            check("tmr_irq", {31'd0, timer_irq}, (k >= 20) ? 32'd1 : 32'd0);
            step();
        end
        rd(TIME_HI_ADDR, "tmr_hi", 32'd0);
        put(1'b1, STATUS_ADDR, 32'h1);
        step();
        check("irq_w1c", {31'd0, timer_irq}, 32'd0);
        put(1'b1, TIME_LO_ADDR, 32'd19);
        step();
        rd(TIME_LO_ADDR, "lo_19", 32'd19);
        check("irq_pre", {31'd0, timer_irq}, 32'd0);
        put(1'b1, STATUS_ADDR, 32'h1);
        step();
        check("irq_setwins", {31'd0, timer_irq}, 32'd1);
        rd(TIME_LO_ADDR, "lo_20", 32'd20);

        // Carry from LO into HI
        put(1'b1, TIMECMP_ADDR, 32'h8000_0000);
        step();
        put(1'b1, STATUS_ADDR, 32'h1);
        step();
        check("irq_clr2", {31'd0, timer_irq}, 32'd0);
        put(1'b1, TIME_HI_ADDR, 32'd5);
        step();
        put(1'b1, TIME_LO_ADDR, 32'hFFFF_FFFF);
        step();
        rd(TIME_LO_ADDR, "lo_max", 32'hFFFF_FFFF);
        rd(TIME_HI_ADDR, "hi_5", 32'd5);
        step();
        rd(TIME_LO_ADDR, "lo_wrap", 32'd0);
        rd(TIME_HI_ADDR, "hi_carry", 32'd6);

        // FIFO fill, overflow, W1C
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put(1'b1, CONSOLE_TX_ADDR, 32'h41 + 32'(i));
            step();
        end
        rd(STATUS_ADDR, "stat_full", 32'h0000_0802);
        check("full_txv", {31'd0, tx_valid}, 32'd1);
        check("full_head", {24'd0, tx_data}, 32'h41);
        put(1'b1, CONSOLE_TX_ADDR, 32'h49);
        step();
        rd(STATUS_ADDR, "stat_ovf", 32'h0000_080A);
        check("ovf_head", {24'd0, tx_data}, 32'h41);
        put(1'b1, STATUS_ADDR, 32'h8);
        step();
        rd(STATUS_ADDR, "ovf_w1c", 32'h0000_0802);

        // Full FIFO: push and pop in the same cycle
        tx_ready = 1'b1;
        put(1'b1, CONSOLE_TX_ADDR, 32'h5A);
        check("pp_head", {24'd0, tx_data}, 32'h41);
        step();
        rd(STATUS_ADDR, "pp_stat", 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            check("drain_v", {31'd0, tx_valid}, 32'd1);
            check("drain_d", {24'd0, tx_data}, {24'd0, drain_exp[i]});
            step();
        end
        check("drained_v", {31'd0, tx_valid}, 32'd0);
        rd(STATUS_ADDR, "drained_stat", 32'h0000_0004);

        // Empty FIFO with push and ready together
        put(1'b1, CONSOLE_TX_ADDR, 32'h77);
        check("ep_pre", {31'd0, tx_valid}, 32'd0);
        step();
        put(1'b0, STATUS_ADDR, 32'd0);
        check("ep_v", {31'd0, tx_valid}, 32'd1);
        check("ep_d", {24'd0, tx_data}, 32'h77);
        step();
        check("ep_gone", {31'd0, tx_valid}, 32'd0);

        // Unmapped accesses
        rd(32'h0002_0000, "unmap_rd", 32'd0);
        check("berr_pre", {31'd0, bus_err}, 32'd0);
        step();
        check("berr_set", {31'd0, bus_err}, 32'd1);
        put(1'b1, 32'h0002_0000, 32'hBAD0_BAD0);
        step();
        rd(TIMECMP_ADDR, "unmap_cmp", 32'h8000_0000);
        check("berr_sticky", {31'd0, bus_err}, 32'd1);
        rd(32'h0000_0000, "unmap_ram0", 32'h1111_1111);
        step();
        check("berr_hold", {31'd0, bus_err}, 32'd1);

        // Asynchronous reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, CONSOLE_TX_ADDR, 32'h61 + 32'(i));
            step();
        end
        put(1'b0, TIME_LO_ADDR, 32'd0);
        check("q3_v", {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("ar_txv", {31'd0, tx_valid}, 32'd0);
        check("ar_txd", {24'd0, tx_data}, 32'd0);
        check("ar_berr", {31'd0, bus_err}, 32'd0);
        rd(TIMECMP_ADDR, "ar_tcmp", 32'hFFFF_FFFF);
        rd(32'h0000_0010, "ar_ram", 32'hDEAD_BEEF);
        step();
        reset = 1'b1;
        rd(TIME_LO_ADDR, "ar_lo0", 32'd0);
        step();
        rd(TIME_LO_ADDR, "ar_lo1", 32'd1);
        step();
        rd(TIME_LO_ADDR, "ar_lo2", 32'd2);
        check("ar_txv2", {31'd0, tx_valid}, 32'd0);
        rd(STATUS_ADDR, "ar_stat", 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_dmem_bus.md
Name: riscv_dmem_bus

Overview:
- Data-side responder for the single-cycle RISC-V CPU; the target end of its MemWrite / address / write-data / ReadData interface.
- Decodes each access to one of: word RAM, free-running 64-bit cycle timer with compare interrupt, or console TX FIFO drained by an external ready/valid sink.
- Read path is combinational, so the CPU completes loads in the same cycle; all state updates on the rising clk edge.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words; power of 2, max 16384.
- FIFO_DEPTH, 8, console TX FIFO entries; power of 2, 2..128.
- TICK_DIV, 1, clk cycles per timer increment; 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_write  in  1  store strobe from CPU (MemWrite).
- addr  in  32  byte address (Mem_WrAddr); addr[1:0] ignored, word accesses only.
- wdata  in  32  store data (Mem_WrData).
- rdata  out  32  load data (ReadData), combinational from addr.
- tx_data  out  8  console byte at FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts tx_data this cycle.
- timer_irq  out  1  timer interrupt pending (level).
- bus_err  out  1  sticky: access hit an unmapped address.

Behaviour:
- Address map (word-aligned):
  - RAM: 0x0000_0000 .. RAM_WORDS*4-1.
  - TIME_LO 0x0001_0000, TIME_HI 0x0001_0004: R/W; a write loads that half.
  - TIMECMP 0x0001_0008: R/W.
  - STATUS 0x0001_000C: bit0 irq_pend (W1C); bit1 fifo_full (RO); bit2 fifo_empty (RO); bit3 tx_overflow (W1C); bits[15:8] fifo_count (RO); other bits read 0.
  - CONSOLE_TX 0x0001_0010: a write pushes wdata[7:0]; reads return 0.
  - Any other address: read returns 0, write ignored, bus_err set.
- bus_err is set on any cycle where addr is unmapped, whether or not mem_write is high. Cleared only by reset.
- RAM:
  - Asynchronous read; write on clk edge when mem_write=1.
  - Read-during-write to the same word returns the old data.
  - Contents are not reset.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; the 64-bit time register increments by 1 as the prescaler wraps, with carry from LO into HI.
  - A CPU write to TIME_LO or TIME_HI overrides the increment for that half in that cycle.
  - When the prescaler wraps and the next time value's low word equals TIMECMP, irq_pend is set.
  - timer_irq = irq_pend.
  - If a set and a W1C clear happen in the same cycle, the set wins.
  - No HI/LO read snapshot; software uses the hi-lo-hi read sequence.
- FIFO:
  - Push on write to CONSOLE_TX; pop when tx_valid && tx_ready.
  - Full with no pop: the push is dropped, tx_overflow is set, contents are unchanged.
  - Full with a simultaneous pop: the push is accepted and count stays FIFO_DEPTH.
  - Empty with a simultaneous push: no pop happens; tx_valid rises the next cycle.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Reset (reset=0, asynchronous, including mid-operation):
  - time=0, prescaler=0, TIMECMP=0xFFFF_FFFF.
  - irq_pend, tx_overflow and bus_err = 0.
  - FIFO flushed: tx_valid=0 immediately, tx_data=0.
  - rdata follows the reset register values; RAM reads are unaffected.
- Latency: loads 0 cycles; store effects are visible from the next cycle; FIFO push to tx_valid is 1 cycle.

Decomposition:
- Shared package riscv_bus_pkg holds:
  - Address constants: RAM_BASE, TIME_LO_ADDR, TIME_HI_ADDR, TIMECMP_ADDR, STATUS_ADDR, CONSOLE_TX_ADDR.
  - STATUS bit-index constants.
- One sub-module: console_txfifo (parameterised synchronous FIFO with push, pop, full, empty, count and head outputs).
- Address decode, timer and RAM stay in the top level.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> rdata=0xDEADBEEF. Load 0x0000_0014 after writing 0x1 there -> 0x1.
- TICK_DIV=1: write TIMECMP=20, TIME_LO=0 -> timer_irq rises when TIME_LO reaches 20. Write STATUS=0x1 -> timer_irq=0 next cycle. Clear coinciding with a match -> timer_irq stays 1.
- tx_ready=0: write 0x41..0x48 to CONSOLE_TX -> STATUS[15:8]=8, bit1=1. Ninth write -> bit3=1 and count stays 8. Raise tx_ready -> 0x41..0x48 appear in order, one per cycle.
- Full FIFO with tx_ready=1 while writing 0x5A -> count remains 8, no overflow, 0x5A emitted last.
- Load 0x0002_0000 -> rdata=0, bus_err=1 and stays 1. Store there -> no RAM or register change.
- Assert reset mid-drain with 3 bytes queued -> tx_valid=0 and bus_err=0 immediately. After release, TIMECMP reads 0xFFFF_FFFF and TIME_LO counts up from 0.
